// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// Single outstanding request: imem_req/imem_addr are held by the master until
// the slave answers with imem_ack (which may be combinational from imem_req).
//   imem_req   : master -> slave, fetch request
//   imem_addr  : master -> slave, word-aligned fetch address
//   imem_ack   : slave -> master, imem_rdata is valid this cycle
//   imem_rdata : slave -> master, fetched instruction word
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, issues one outstanding fetch at a
// time on the imem bus and presents {PC, instruction, valid} to IF/ID.
// Ports:
//   clk_IF       : clock, rising edge
//   rst_IF       : asynchronous active-high reset
//   stall_IF     : hold the currently presented instruction
//   redirect_IF  : taken branch/jump, wins over stall_IF
//   target_IF    : redirect target, bits [1:0] ignored
//   imem         : fetch bus (master side)
//   PC_out_IF    : PC of the presented instruction
//   inst_out_IF  : presented instruction
//   valid_IF     : presented instruction is real; IF/ID enable is valid_IF & ~stall_IF
// Optional feature (macro IF_PERF_CNT_EN):
//   fetch_cnt_IF : consumed-instruction count, wraps
//   flush_cnt_IF : redirects taken in FETCH/HOLD/DISCARD, wraps
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_IF,
    input  logic        rst_IF,
    input  logic        stall_IF,
    input  logic        redirect_IF,
    input  logic [31:0] target_IF,
    if_fetch_stage_if.master imem,
    output logic [31:0] PC_out_IF,
    output logic [31:0] inst_out_IF,
    output logic        valid_IF
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_IF,
    output logic [31:0] flush_cnt_IF
`endif
);

    localparam logic [31:0] ResetPc = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] Nop     = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        consume;
    logic        flush;
    logic [31:0] target;

    assign target = target_IF & 32'hFFFF_FFFC;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        consume  = 1'b0;
        flush    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_d   = 1'b1;
                state_d = StFetch;
                if (redirect_IF) begin
                    pc_d   = target;
                    addr_d = target;
                end else begin
                    addr_d = pc_q;
                end
            end

            // stall_IF has no effect here: nothing is presented yet.
            StFetch: begin
                if (redirect_IF) begin
                    flush = 1'b1;
                    pc_d  = target;
                    if (imem.imem_ack) begin
                        // Returned word is stale; re-issue at the target right away.
                        addr_d = target;
                    end else begin
                        // Address must stay stable until the stale ack drains.
                        state_d = StDiscard;
                    end
                end else if (imem.imem_ack) begin
                    inst_d   = imem.imem_rdata;
                    pc_out_d = addr_q;
                    valid_d  = 1'b1;
                    pc_d     = addr_q + 32'd4;
                    req_d    = 1'b0;
                    state_d  = StHold;
                end
            end

            StHold: begin
                if (redirect_IF) begin
                    flush   = 1'b1;
                    valid_d = 1'b0;
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = StFetch;
                end else if (!stall_IF) begin
                    consume = 1'b1;
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = StFetch;
                end
            end

            StDiscard: begin
                if (redirect_IF) begin
                    flush = 1'b1;
                    pc_d  = target;
                end
                if (imem.imem_ack) begin
                    // Ack data is dropped; the latest redirect target wins.
                    addr_d  = redirect_IF ? target : pc_q;
                    state_d = StFetch;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_IF or posedge rst_IF) begin
        if (rst_IF) begin
            state_q  <= StIdle;
            pc_q     <= ResetPc;
            req_q    <= 1'b0;
            addr_q   <= ResetPc;
            pc_out_q <= 32'h0000_0000;
            inst_q   <= Nop;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign PC_out_IF      = pc_out_q;
    assign inst_out_IF    = inst_q;
    assign valid_IF       = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_IF or posedge rst_IF) begin
        if (rst_IF) begin
            fetch_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else begin
            if (consume) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush)   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_IF = fetch_cnt_q;
    assign flush_cnt_IF = flush_cnt_q;
`else
    // Counter strobes only feed the optional performance counters.
    logic unused_perf;
    assign unused_perf = consume ^ flush;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed stimulus, an instruction-memory model with
// programmable wait cycles, and a scoreboard queue of expected {PC, inst}
// presentations checked by an independent monitor.
module tb_if_fetch_stage;

    logic        clk_IF = 1'b0;
    logic        rst_IF = 1'b1;
    logic        stall_IF = 1'b0;
    logic        redirect_IF = 1'b0;
    logic [31:0] target_IF = 32'h0;
    logic [31:0] PC_out_IF;
    logic [31:0] inst_out_IF;
    logic        valid_IF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_IF;
    logic [31:0] flush_cnt_IF;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned mem_wait = 0;
    int unsigned wait_cnt;

    logic [63:0] exp_q[$];

    if_fetch_stage_if imem_bus ();

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_IF      (clk_IF),
        .rst_IF      (rst_IF),
        .stall_IF    (stall_IF),
        .redirect_IF (redirect_IF),
        .target_IF   (target_IF),
        .imem        (imem_bus.master),
        .PC_out_IF   (PC_out_IF),
        .inst_out_IF (inst_out_IF),
        .valid_IF    (valid_IF)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_IF(fetch_cnt_IF),
        .flush_cnt_IF(flush_cnt_IF)
`endif
    );

    initial forever #5 clk_IF = ~clk_IF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Memory: ack after mem_wait cycles of a held request, combinational in the last.
    always_ff @(posedge clk_IF or posedge rst_IF) begin
        if (rst_IF) wait_cnt <= 0;
        else if (!imem_bus.imem_req || imem_bus.imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt == mem_wait);
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_IF);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (valid_IF) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen && !valid_IF) begin
            checks++;
            errors++;
            $display("FAIL %s: valid_IF timeout got 0 expected 1", name);
        end
    endtask

    // Monitor: every new presentation (valid rising) must match the queue head.
    initial begin
        logic        prev_valid = 1'b0;
        logic [63:0] e;
        forever begin
            @(negedge clk_IF);
            if (!rst_IF && valid_IF && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %08h expected no presentation", PC_out_IF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", PC_out_IF, e[63:32]);
                    chk("sb_inst", inst_out_IF, e[31:0]);
                end
            end
            prev_valid = valid_IF;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rst_addr", imem_bus.imem_addr, 32'h0);
        chk("rst_pc_out", PC_out_IF, 32'h0);
        chk("rst_inst", inst_out_IF, 32'h0000_0013);
        chk("rst_valid", {31'b0, valid_IF}, 32'd0);

        // Zero-wait streaming 0,4,8
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        rst_IF = 1'b0;
        step();
        chk("t1_e1_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("t1_e1_addr", imem_bus.imem_addr, 32'h0);
        step();
        chk("t1_e2_valid", {31'b0, valid_IF}, 32'd1);
        chk("t1_e2_req", {31'b0, imem_bus.imem_req}, 32'd0);
        step();
        chk("t1_e3_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("t1_e3_addr", imem_bus.imem_addr, 32'h4);
        chk("t1_e3_valid", {31'b0, valid_IF}, 32'd0);
        step();
        chk("t1_e4_pc", PC_out_IF, 32'h4);
        step();
        chk("t1_e5_addr", imem_bus.imem_addr, 32'h8);
        step();
        chk("t1_e6_pc", PC_out_IF, 32'h8);

        // Stall in HOLD for three cycles
        stall_IF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_valid", {31'b0, valid_IF}, 32'd1);
            chk("t2_pc", PC_out_IF, 32'h8);
            chk("t2_inst", inst_out_IF, mem_word(32'h8));
            chk("t2_req", {31'b0, imem_bus.imem_req}, 32'd0);
        end
        stall_IF = 1'b0;
        push_exp(32'hC);
        step();
        chk("t2_next_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("t2_next_addr", imem_bus.imem_addr, 32'hC);
        step();
        chk("t2_pc_c", PC_out_IF, 32'hC);

        // Two wait cycles, redirect during the first one
        mem_wait = 2;
        push_exp(32'h100);
        step();
        chk("t3_addr16", imem_bus.imem_addr, 32'h10);
        redirect_IF = 1'b1;
        target_IF   = 32'h0000_0100;
        step();
        redirect_IF = 1'b0;
        chk("t3_disc_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("t3_disc_addr", imem_bus.imem_addr, 32'h10);
        step();
        chk("t3_disc_addr2", imem_bus.imem_addr, 32'h10);
        chk("t3_disc_valid", {31'b0, valid_IF}, 32'd0);
        step();
        chk("t3_refetch_addr", imem_bus.imem_addr, 32'h100);
        chk("t3_refetch_valid", {31'b0, valid_IF}, 32'd0);
        wait_valid(10, "t3_wait");
        chk("t3_pc", PC_out_IF, 32'h100);

        // Redirect to unaligned target while stalled in HOLD
        mem_wait    = 0;
        stall_IF    = 1'b1;
        redirect_IF = 1'b1;
        target_IF   = 32'h0000_0203;
        push_exp(32'h200);
        step();
        redirect_IF = 1'b0;
        chk("t4_valid", {31'b0, valid_IF}, 32'd0);
        chk("t4_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("t4_addr", imem_bus.imem_addr, 32'h200);
        step();
        chk("t4_pc", PC_out_IF, 32'h200);
        stall_IF = 1'b0;
        step();
        chk("t4_next_addr", imem_bus.imem_addr, 32'h204);

        // Redirect in FETCH with ack, then wrap at the top of the address space
        redirect_IF = 1'b1;
        target_IF   = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        step();
        redirect_IF = 1'b0;
        chk("t5_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk("t5_valid", {31'b0, valid_IF}, 32'd0);
        step();
        chk("t5_pc", PC_out_IF, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_addr", imem_bus.imem_addr, 32'h0);
        step();
        chk("t5_wrap_pc", PC_out_IF, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("t5_fetch_cnt", fetch_cnt_IF, 32'd6);
        chk("t5_flush_cnt", flush_cnt_IF, 32'd3);
`endif

        // Asynchronous reset mid-fetch
        mem_wait = 3;
        step();
        chk("t6_pre_req", {31'b0, imem_bus.imem_req}, 32'd1);
        #2;
        rst_IF = 1'b1;
        #1;
        chk("t6_rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("t6_rst_addr", imem_bus.imem_addr, 32'h0);
        chk("t6_rst_inst", inst_out_IF, 32'h0000_0013);
`ifdef IF_PERF_CNT_EN
        chk("t6_rst_fetch_cnt", fetch_cnt_IF, 32'd0);
        chk("t6_rst_flush_cnt", flush_cnt_IF, 32'd0);
`endif

        // Redirect from IDLE, then redirects in FETCH and DISCARD (latest wins)
        mem_wait    = 1;
        redirect_IF = 1'b1;
        target_IF   = 32'h0000_0040;
        step();
        rst_IF = 1'b0;
        step();
        chk("t7_idle_addr", imem_bus.imem_addr, 32'h40);
        chk("t7_idle_req", {31'b0, imem_bus.imem_req}, 32'd1);
        target_IF = 32'h0000_0080;
        step();
        chk("t7_disc_addr", imem_bus.imem_addr, 32'h40);
        target_IF = 32'h0000_00C0;
        push_exp(32'hC0);
        step();
        redirect_IF = 1'b0;
        chk("t7_latest_addr", imem_bus.imem_addr, 32'hC0);
        chk("t7_latest_valid", {31'b0, valid_IF}, 32'd0);
        wait_valid(10, "t7_wait");
        chk("t7_pc", PC_out_IF, 32'hC0);
        step();
        chk("t7_next_addr", imem_bus.imem_addr, 32'hC4);
`ifdef IF_PERF_CNT_EN
        chk("t7_fetch_cnt", fetch_cnt_IF, 32'd1);
        chk("t7_flush_cnt", flush_cnt_IF, 32'd2);
`endif

        @(negedge clk_IF);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
